// File: rtl/down_link_arbiter.sv
// rtl/down_link_arbiter.sv - credit-based packet arbiter for three requesters onto one downstream link
module down_link_arbiter #(
    parameter int NUM_CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vc0,
    input  logic       req_vc1,
    input  logic       req_ni,
    input  logic [7:0] flit_vc0,
    input  logic [7:0] flit_vc1,
    input  logic [7:0] flit_ni,
    input  logic       credit_in,
    output logic [2:0] pop,
    output logic [2:0] grant,
    output logic [7:0] flit_out_down,
    output logic       valid_out,
    output logic [2:0] credits,
    output logic       err
);

    localparam logic [2:0] CRED_MAX = 3'(NUM_CREDITS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] credits_q, credits_d;
    logic [7:0] flit_q, flit_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic [2:0] req_v;
    logic [2:0] elig;
    logic [2:0] rot;
    logic [2:0] pri;
    logic [2:0] win;
    logic       owner_req;
    logic [7:0] owner_flit;
    logic [2:0] pop_c;
    logic       accept;
    logic [7:0] acc_flit;

    assign req_v = {req_ni, req_vc1, req_vc0};
    assign elig  = {req_ni  && (flit_ni[7:6]  == 2'b01),
                    req_vc1 && (flit_vc1[7:6] == 2'b01),
                    req_vc0 && (flit_vc0[7:6] == 2'b01)};

    // Rotate so that the pointer position is bit 0, priority-encode, rotate back.
    always_comb begin
        rot = elig;
        case (ptr_q)
            2'd1:    rot = {elig[0], elig[2], elig[1]};
            2'd2:    rot = {elig[1], elig[0], elig[2]};
            default: rot = elig;
        endcase
        pri = 3'b000;
        if (rot[0])      pri = 3'b001;
        else if (rot[1]) pri = 3'b010;
        else if (rot[2]) pri = 3'b100;
        win = pri;
        case (ptr_q)
            2'd1:    win = {pri[1], pri[0], pri[2]};
            2'd2:    win = {pri[0], pri[2], pri[1]};
            default: win = pri;
        endcase
    end

    always_comb begin
        owner_req  = |(req_v & grant_q);
        owner_flit = 8'h00;
        case (grant_q)
            3'b001:  owner_flit = flit_vc0;
            3'b010:  owner_flit = flit_vc1;
            3'b100:  owner_flit = flit_ni;
            default: owner_flit = 8'h00;
        endcase
    end

    // Output process: pop is combinational and forced low while in reset.
    always_comb begin
        pop_c = 3'b000;
        if (!rst && credits_q != 3'd0) begin
            case (state_q)
                IDLE:    pop_c = win;
                LOCKED:  if (owner_req && owner_flit[7]) pop_c = grant_q;
                default: pop_c = 3'b000;
            endcase
        end
    end

    always_comb begin
        accept   = |pop_c;
        acc_flit = 8'h00;
        case (pop_c)
            3'b001:  acc_flit = flit_vc0;
            3'b010:  acc_flit = flit_vc1;
            3'b100:  acc_flit = flit_ni;
            default: acc_flit = 8'h00;
        endcase
    end

    // Next-state process.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        credits_d = credits_q;
        err_d     = err_q;
        valid_d   = accept;
        flit_d    = accept ? acc_flit : flit_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOCKED;
                    grant_d = pop_c;
                end
            end
            LOCKED: begin
                if (accept && acc_flit[7:6] == 2'b11) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                    case (grant_q)
                        3'b001:  ptr_d = 2'd1;
                        3'b010:  ptr_d = 2'd2;
                        default: ptr_d = 2'd0;
                    endcase
                end
                if (owner_req && !owner_flit[7]) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        case ({accept, credit_in})
            2'b10: credits_d = credits_q - 3'd1;
            2'b01: begin
                if (credits_q == CRED_MAX) err_d = 1'b1;
                else credits_d = credits_q + 3'd1;
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 3'b000;
            ptr_q     <= 2'd0;
            credits_q <= CRED_MAX;
            flit_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            flit_q    <= flit_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign pop           = pop_c;
    assign grant         = grant_q;
    assign flit_out_down = flit_q;
    assign valid_out     = valid_q;
    assign credits       = credits_q;
    assign err           = err_q;

endmodule

// File: tb/tb_down_link_arbiter.sv
// tb/tb_down_link_arbiter.sv - directed self-checking bench for down_link_arbiter
module tb_down_link_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_vc0 = 1'b0, req_vc1 = 1'b0, req_ni = 1'b0;
    logic [7:0] flit_vc0 = 8'h00, flit_vc1 = 8'h00, flit_ni = 8'h00;
    logic       credit_in = 1'b0;
    logic [2:0] pop, grant, credits;
    logic [7:0] flit_out_down;
    logic       valid_out, err;

    int n_cmp = 0;
    int n_bad = 0;

    down_link_arbiter #(.NUM_CREDITS(4)) dut (
        .clk(clk), .rst(rst),
        .req_vc0(req_vc0), .req_vc1(req_vc1), .req_ni(req_ni),
        .flit_vc0(flit_vc0), .flit_vc1(flit_vc1), .flit_ni(flit_ni),
        .credit_in(credit_in), .pop(pop), .grant(grant),
        .flit_out_down(flit_out_down), .valid_out(valid_out),
        .credits(credits), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check pop before the rising edge, settle after it.
    task automatic cyc(input logic [2:0] rq, input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic ci, input logic [2:0] exp_pop,
                       input string tag);
        @(negedge clk);
        req_vc0 = rq[0]; req_vc1 = rq[1]; req_ni = rq[2];
        flit_vc0 = f0; flit_vc1 = f1; flit_ni = f2;
        credit_in = ci;
        #1 check({tag, "_pop"}, 32'(pop), 32'(exp_pop));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_vc0 = 1'b0; req_vc1 = 1'b0; req_ni = 1'b0;
        flit_vc0 = 8'h00; flit_vc1 = 8'h00; flit_ni = 8'h00;
        credit_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] rr_exp [8];
    logic [2:0] ph;
    logic [7:0] fv [3];
    logic [7:0] exp_flit;

    initial begin
        rr_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};

        // Reset state, with a head pending so pop must still be held low
        req_vc0 = 1'b1; flit_vc0 = 8'h41;
        #12;
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_credits", 32'(credits), 32'h4);
        check("rst_err", 32'(err), 32'h0);
        check("rst_flit", 32'(flit_out_down), 32'h00);
        do_reset();

        // Type-00 request ignored in IDLE without error
        cyc(3'b001, 8'h00, 8'h00, 8'h00, 1'b0, 3'b000, "inv_idle");
        check("inv_idle_err", 32'(err), 32'h0);
        check("inv_idle_grant", 32'(grant), 32'h0);

        // Single VC0 packet 41h, 82h, C3h
        cyc(3'b001, 8'h41, 8'h00, 8'h00, 1'b0, 3'b001, "vc0_h");
        check("vc0_h_flit", 32'(flit_out_down), 32'h41);
        check("vc0_h_valid", 32'(valid_out), 32'h1);
        check("vc0_h_grant", 32'(grant), 32'h1);
        check("vc0_h_cred", 32'(credits), 32'h3);
        cyc(3'b001, 8'h82, 8'h00, 8'h00, 1'b0, 3'b001, "vc0_b");
        check("vc0_b_flit", 32'(flit_out_down), 32'h82);
        check("vc0_b_cred", 32'(credits), 32'h2);
        cyc(3'b001, 8'hC3, 8'h00, 8'h00, 1'b0, 3'b001, "vc0_t");
        check("vc0_t_flit", 32'(flit_out_down), 32'hC3);
        check("vc0_t_valid", 32'(valid_out), 32'h1);
        check("vc0_t_cred", 32'(credits), 32'h1);
        check("vc0_t_grant", 32'(grant), 32'h0);
        cyc(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 3'b000, "vc0_idle");
        check("vc0_idle_valid", 32'(valid_out), 32'h0);
        check("vc0_idle_flit", 32'(flit_out_down), 32'hC3);

        // Round-robin across three two-flit packets, credit returned every cycle
        do_reset();
        ph = 3'b000;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) fv[i] = (ph[i] ? 8'hC0 : 8'h40) | 8'(i);
            exp_flit = rr_exp[k][0] ? fv[0] : (rr_exp[k][1] ? fv[1] : fv[2]);
            cyc(3'b111, fv[0], fv[1], fv[2], 1'b1, rr_exp[k], $sformatf("rr%0d", k));
            check($sformatf("rr%0d_flit", k), 32'(flit_out_down), 32'(exp_flit));
            ph = ph ^ rr_exp[k];
        end
        check("rr_cred", 32'(credits), 32'h4);
        check("rr_err", 32'(err), 32'h0);

        // Credit return at full count sets err, count saturates
        cyc(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, "ovf");
        check("ovf_err", 32'(err), 32'h1);
        check("ovf_cred", 32'(credits), 32'h4);

        // Six-flit VC1 packet against four credits
        do_reset();
        cyc(3'b010, 8'h00, 8'h41, 8'h00, 1'b0, 3'b010, "st0");
        cyc(3'b010, 8'h00, 8'h82, 8'h00, 1'b0, 3'b010, "st1");
        cyc(3'b010, 8'h00, 8'h83, 8'h00, 1'b0, 3'b010, "st2");
        cyc(3'b010, 8'h00, 8'h84, 8'h00, 1'b0, 3'b010, "st3");
        check("st3_cred", 32'(credits), 32'h0);
        cyc(3'b010, 8'h00, 8'h85, 8'h00, 1'b0, 3'b000, "st4");
        check("st4_grant", 32'(grant), 32'h2);
        check("st4_valid", 32'(valid_out), 32'h0);
        cyc(3'b010, 8'h00, 8'h85, 8'h00, 1'b1, 3'b000, "st5");
        check("st5_cred", 32'(credits), 32'h1);
        cyc(3'b010, 8'h00, 8'h85, 8'h00, 1'b0, 3'b010, "st6");
        check("st6_flit", 32'(flit_out_down), 32'h85);
        check("st6_cred", 32'(credits), 32'h0);
        cyc(3'b010, 8'h00, 8'hC6, 8'h00, 1'b0, 3'b000, "st7");
        check("st7_grant", 32'(grant), 32'h2);

        // Head presented by the owner while locked
        do_reset();
        cyc(3'b001, 8'h41, 8'h00, 8'h00, 1'b0, 3'b001, "hd0");
        cyc(3'b001, 8'h41, 8'h00, 8'h00, 1'b0, 3'b000, "hd1");
        check("hd1_err", 32'(err), 32'h1);
        check("hd1_grant", 32'(grant), 32'h1);
        check("hd1_valid", 32'(valid_out), 32'h0);

        // Reset mid-packet on VC1, then VC0 wins from a clean pointer
        do_reset();
        cyc(3'b010, 8'h00, 8'h41, 8'h00, 1'b0, 3'b010, "mr0");
        cyc(3'b010, 8'h00, 8'h82, 8'h00, 1'b0, 3'b010, "mr1");
        check("mr1_flit", 32'(flit_out_down), 32'h82);
        #2 rst = 1'b1;
        #1;
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_valid", 32'(valid_out), 32'h0);
        check("mr_cred", 32'(credits), 32'h4);
        check("mr_err", 32'(err), 32'h0);
        check("mr_pop", 32'(pop), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(3'b011, 8'h41, 8'h41, 8'h00, 1'b0, 3'b001, "mr2");
        check("mr2_grant", 32'(grant), 32'h1);
        check("mr2_flit", 32'(flit_out_down), 32'h41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
